// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the 8x8 sequential multiplier: a Moore FSM that steps
// the shared 4x4 multiplier/shifter through the four nibble partial products into reg16.
module mult_seq_ctrl (
  input  logic       clk,
  input  logic       aclr_n,
  input  logic       start,
  input  logic       abort,
  output logic [1:0] input_sel,
  output logic [1:0] shift_sel,
  output logic       clk_ena,
  output logic       sclr_n,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_out
);

  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_CLEAR   = 3'b001;
  localparam logic [2:0] S_LSB     = 3'b010;
  localparam logic [2:0] S_MID1    = 3'b011;
  localparam logic [2:0] S_MID2    = 3'b100;
  localparam logic [2:0] S_MSB     = 3'b101;
  localparam logic [2:0] S_DONE    = 3'b110;

  logic [2:0] state;
  logic [2:0] next_state;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // abort takes priority over sequencing in every active state; 111 falls back to IDLE
  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:  next_state = start ? S_CLEAR : S_IDLE;
      S_CLEAR: next_state = abort ? S_IDLE : S_LSB;
      S_LSB:   next_state = abort ? S_IDLE : S_MID1;
      S_MID1:  next_state = abort ? S_IDLE : S_MID2;
      S_MID2:  next_state = abort ? S_IDLE : S_MSB;
      S_MSB:   next_state = abort ? S_IDLE : S_DONE;
      S_DONE:  next_state = start ? S_DONE : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    clk_ena   = 1'b0;
    sclr_n    = 1'b1;
    input_sel = 2'b00;
    shift_sel = 2'b00;
    busy      = 1'b0;
    done      = 1'b0;
    state_out = S_IDLE;
    case (state)
      S_CLEAR: begin
        clk_ena   = 1'b1;
        sclr_n    = 1'b0;
        busy      = 1'b1;
        state_out = S_CLEAR;
      end
      S_LSB: begin
        clk_ena   = 1'b1;
        busy      = 1'b1;
        state_out = S_LSB;
      end
      S_MID1: begin
        clk_ena   = 1'b1;
        input_sel = 2'b01;
        shift_sel = 2'b01;
        busy      = 1'b1;
        state_out = S_MID1;
      end
      S_MID2: begin
        clk_ena   = 1'b1;
        input_sel = 2'b10;
        shift_sel = 2'b01;
        busy      = 1'b1;
        state_out = S_MID2;
      end
      S_MSB: begin
        clk_ena   = 1'b1;
        input_sel = 2'b11;
        shift_sel = 2'b10;
        busy      = 1'b1;
        state_out = S_MSB;
      end
      S_DONE: begin
        done      = 1'b1;
        state_out = S_DONE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: a behavioural 4x4 multiplier/shifter/reg16 datapath is
// steered by the DUT outputs, and finished products are compared against a queue.
module tb_mult_seq_ctrl;

  logic       clk;
  logic       aclr_n;
  logic       start;
  logic       abort;
  logic [1:0] input_sel;
  logic [1:0] shift_sel;
  logic       clk_ena;
  logic       sclr_n;
  logic       busy;
  logic       done;
  logic [2:0] state_out;

  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [15:0] acc;
  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [15:0] addend;

  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  mult_seq_ctrl dut (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .start     (start),
    .abort     (abort),
    .input_sel (input_sel),
    .shift_sel (shift_sel),
    .clk_ena   (clk_ena),
    .sclr_n    (sclr_n),
    .busy      (busy),
    .done      (done),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: nibble-pair select, shift by 0/4/8, accumulate into reg16
  always_comb begin
    a_nib  = input_sel[1] ? op_a[7:4] : op_a[3:0];
    b_nib  = input_sel[0] ? op_b[7:4] : op_b[3:0];
    addend = 16'(a_nib) * 16'(b_nib);
    case (shift_sel)
      2'b01:   addend = addend << 4;
      2'b10:   addend = addend << 8;
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (clk_ena) acc <= sclr_n ? acc + addend : 16'h0000;
  end

  function automatic logic [7:0] exp_outs(input int s);
    case (s)
      1:       return 8'b1_0_00_00_1_0;
      2:       return 8'b1_1_00_00_1_0;
      3:       return 8'b1_1_01_01_1_0;
      4:       return 8'b1_1_10_01_1_0;
      5:       return 8'b1_1_11_10_1_0;
      6:       return 8'b0_1_00_00_0_1;
      default: return 8'b0_1_00_00_0_0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_state(input string tag, input int s);
    checkOutput({tag, " state"}, 16'(state_out), 16'(s));
    checkOutput({tag, " outs"}, 16'({clk_ena, sclr_n, input_sel, shift_sel, busy, done}), 16'(exp_outs(s)));
  endtask

  // Drive operands and start just after a falling edge; record the expected product
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input bit push);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    if (push) exp_q.push_back(16'(a) * 16'(b));
  endtask

  // Follow one operation to DONE with a cycle budget, then pop and compare the product
  task automatic wait_done(input string tag, input bit hold_start);
    int lat;
    int busy_n;
    logic [15:0] expv;
    lat = 0;
    busy_n = 0;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && !hold_start) start = 1'b0;
      if (busy) busy_n++;
      if (done) break;
      if (lat <= 5) check_state({tag, " seq"}, lat);
    end
    checkOutput({tag, " latency"}, 16'(lat), 16'd6);
    checkOutput({tag, " busy_cycles"}, 16'(busy_n), 16'd5);
    check_state({tag, " done"}, 6);
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      checkOutput({tag, " product"}, acc, expv);
    end else begin
      checkOutput({tag, " scoreboard_empty"}, 16'd0, 16'd1);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s);
    int n;
    n = 0;
    while (state_out !== s && n < 12) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " reached"}, 16'(state_out), 16'(s));
  endtask

  initial begin
    aclr_n = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    op_a   = 8'h00;
    op_b   = 8'h00;
    acc    = 16'h0000;

    // Reset state
    #12;
    check_state("reset", 0);
    @(negedge clk);
    aclr_n = 1'b1;
    repeat (2) @(negedge clk);
    check_state("idle_hold", 0);

    // Basic multiply with full sequence/latency checks
    applyStimulus(8'h12, 8'h34, 1'b1);
    wait_done("basic", 1'b0);
    @(negedge clk);
    check_state("basic_to_idle", 0);
    checkOutput("basic_product_kept", acc, 16'h03A8);

    // Corner operands
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    wait_done("ffxff", 1'b0);
    applyStimulus(8'h00, 8'hA5, 1'b1);
    wait_done("zero", 1'b0);
    applyStimulus(8'h80, 8'h02, 1'b1);
    wait_done("x80x02", 1'b0);

    // Async reset in the middle of MID1
    applyStimulus(8'h55, 8'h55, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_state("rst_mid1", 3'b011);
    #1 aclr_n = 1'b0;
    #1 check_state("async_reset", 0);
    @(negedge clk);
    aclr_n = 1'b1;
    repeat (3) @(negedge clk);
    check_state("post_reset_idle", 0);

    // Abort during MID2, then a fresh operation must start from a cleared accumulator
    applyStimulus(8'hAA, 8'h77, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_state("abort", 3'b100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_state("abort_idle", 0);
    repeat (3) @(negedge clk);
    checkOutput("abort_no_done", 16'(done), 16'd0);
    applyStimulus(8'h0F, 8'h0F, 1'b1);
    wait_done("after_abort", 1'b0);

    // Abort wins over start in an active state
    applyStimulus(8'h11, 8'h22, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_state("abort_vs_start", 0);
    start = 1'b0;
    @(negedge clk);

    // Start held high: one pass, then park in DONE until released
    applyStimulus(8'h3C, 8'h5A, 1'b1);
    wait_done("held", 1'b1);
    repeat (8) @(negedge clk);
    check_state("held_stay_done", 6);
    start = 1'b0;
    @(negedge clk);
    check_state("held_release", 0);
    applyStimulus(8'hC3, 8'h9E, 1'b1);
    wait_done("held_second", 1'b0);
    @(negedge clk);

    // Illegal encoding decodes as IDLE and recovers on the next edge
    force dut.state = 3'b111;
    #1 check_state("illegal_decode", 0);
    release dut.state;
    @(negedge clk);
    check_state("illegal_recover", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
